// File: rtl/bram_ctrl_pkg.sv
// rtl/bram_ctrl_pkg.sv - shared types and constants for the BRAM port controller
// Contents: controller state enum, default BRAM geometry (shared with bram),
// BRAM read latency and the derived in-flight pipeline depth.
package bram_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 13;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8192;

    // Registered BRAM: data appears one edge after the address is presented.
    localparam int RD_LATENCY     = 1;
    // One stage for the registered address output plus the BRAM latency.
    localparam int RD_PIPE_STAGES = RD_LATENCY + 1;

    localparam int RSP_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/rsp_fifo2.sv
// rtl/rsp_fifo2.sv - two-entry synchronous FIFO for read responses
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset (empties FIFO)
//   i_in_valid/o_in_ready   push handshake, i_in_data pushed word
//   o_out_valid/i_out_ready pop handshake, o_out_data head word
//   o_count                 current occupancy (0..2)
module rsp_fifo2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_in_ready  = (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_data  = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    assign w_push = i_in_valid & o_in_ready;
    assign w_pop  = o_out_valid & i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/bram_port_ctrl.sv
// rtl/bram_port_ctrl.sv - single-port BRAM initiator with write/read request channels
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset (forces clear sweep)
//   i_clear, o_busy                clear request pulse, busy while draining or clearing
//   i_wr_valid/o_wr_ready, i_wr_addr, i_wr_data   write request channel
//   i_rd_valid/o_rd_ready, i_rd_addr              read request channel
//   o_rsp_valid/i_rsp_ready, o_rsp_data           in-order read responses
//   o_bram_addr/o_bram_write/o_bram_data          registered BRAM port drive
//   i_bram_data                                   BRAM read data (one-cycle latency)
module bram_port_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                    DEPTH       = DEF_DEPTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    output logic                  o_busy,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_valid,
    output logic                  o_rd_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic                  o_bram_write,
    output logic [DATA_WIDTH-1:0] o_bram_data,
    input  logic [DATA_WIDTH-1:0] i_bram_data
);

    ctrl_state_t               r_state;
    ctrl_state_t               w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_sweep_cnt;
    logic [RD_PIPE_STAGES-1:0] r_rd_pipe;
    logic                      r_last_rd;

    logic                      w_sweep_last;
    logic [2:0]                w_inflight;
    logic [2:0]                w_used;
    logic                      w_has_credit;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_fifo_in_ready;
    logic [1:0]                w_fifo_count;
    logic                      w_run_ok;
    logic                      w_rd_elig;
    logic                      w_wr_grant;
    logic                      w_rd_grant;

    assign w_sweep_last = (r_sweep_cnt == ADDR_WIDTH'(DEPTH - 1));

    always_comb begin
        w_inflight = 3'd0;
        for (int i = 0; i < RD_PIPE_STAGES; i++) begin
            w_inflight = w_inflight + 3'(r_rd_pipe[i]);
        end
    end

    // Credits: FIFO slots not yet claimed by an in-flight read or a held response.
    assign w_used       = w_inflight + {1'b0, w_fifo_count};
    assign w_has_credit = (w_used < 3'(RSP_FIFO_DEPTH));
    assign w_pop        = o_rsp_valid & i_rsp_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_sweep_last)        w_state_nxt = ST_RUN;
            ST_RUN:   if (i_clear)             w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_inflight == 3'd0)  w_state_nxt = ST_CLEAR;
            default:                           w_state_nxt = ST_CLEAR;
        endcase
    end

    // ---------------- FSM: outputs / grant arbitration ----------------
    // A read grant is allowed on a pop cycle even with zero credits: the popped
    // slot is freed at the same edge the new read claims one.
    // Write readiness looks at the read channel's valid and eligibility, never at
    // o_rd_ready, so the two ready outputs do not form a combinational loop.
    always_comb begin
        o_busy     = 1'b1;
        w_run_ok   = 1'b0;
        w_rd_elig  = 1'b0;
        o_wr_ready = 1'b0;
        o_rd_ready = 1'b0;
        if (r_state == ST_RUN) begin
            o_busy     = 1'b0;
            w_run_ok   = ~i_clear;
            w_rd_elig  = w_run_ok & (w_has_credit | w_pop);
            o_wr_ready = w_run_ok & ~(i_rd_valid & w_rd_elig & ~r_last_rd);
            o_rd_ready = w_rd_elig & ~(i_wr_valid & w_run_ok & r_last_rd);
        end
    end

    assign w_wr_grant = i_wr_valid & o_wr_ready;
    assign w_rd_grant = i_rd_valid & o_rd_ready;

    // ---------------- BRAM port drive, sweep counter, arbitration flag ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bram_addr  <= '0;
            o_bram_write <= 1'b0;
            o_bram_data  <= '0;
            r_sweep_cnt  <= '0;
            r_last_rd    <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    o_bram_addr  <= r_sweep_cnt;
                    o_bram_write <= 1'b1;
                    o_bram_data  <= CLEAR_VALUE;
                end
                ST_RUN: begin
                    if (w_wr_grant) begin
                        o_bram_addr  <= i_wr_addr;
                        o_bram_write <= 1'b1;
                        o_bram_data  <= i_wr_data;
                    end else if (w_rd_grant) begin
                        o_bram_addr  <= i_rd_addr;
                        o_bram_write <= 1'b0;
                    end else begin
                        o_bram_write <= 1'b0;
                    end
                end
                default: o_bram_write <= 1'b0;
            endcase

            // Counter only runs in CLEAR; leaving any other state parks it at 0
            // so the next sweep always starts from address 0.
            if (r_state == ST_CLEAR) begin
                r_sweep_cnt <= r_sweep_cnt + 1'b1;
            end else begin
                r_sweep_cnt <= '0;
            end

            if (w_wr_grant) begin
                r_last_rd <= 1'b0;
            end else if (w_rd_grant) begin
                r_last_rd <= 1'b1;
            end
        end
    end

    // ---------------- In-flight read tracking ----------------
    // Stage 0: address registered onto the BRAM port; last stage: BRAM data valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[RD_PIPE_STAGES-2:0], w_rd_grant};
        end
    end

    assign w_push = r_rd_pipe[RD_PIPE_STAGES-1] & w_fifo_in_ready;

    rsp_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (w_push),
        .o_in_ready  (w_fifo_in_ready),
        .i_in_data   (i_bram_data),
        .o_out_valid (o_rsp_valid),
        .i_out_ready (i_rsp_ready),
        .o_out_data  (o_rsp_data),
        .o_count     (w_fifo_count)
    );

endmodule
